hud_display: RTL and testbench

HUD_DISPLAY -- requirements
Module: hud_display

---
 rtl/hud_pkg.sv | 38 +++
 rtl/bin2bcd_seq.sv | 70 +++++++
 rtl/hud_display.sv | 133 +++++++++++++
 tb/tb_hud_display.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// Shared types and seven-segment constants for the HUD display block.
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
package hud_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LATCH
  } cvt_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial binary-to-BCD converter (shift-add-3), one bit per cycle.
// done pulses for one cycle in LATCH while bcd holds the final result.
module bin2bcd_seq
  import hud_pkg::*;
#(
  parameter int BIN_W      = 10,
  parameter int BCD_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  cvt_state_t        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [SH_W-1:0]   shreg;

  function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] r;
    r = v;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r[BIN_W + 4*d +: 4] >= 4'd5)
        r[BIN_W + 4*d +: 4] = r[BIN_W + 4*d +: 4] + 4'd3;
    end
    return r << 1;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONVERT;
      CONVERT: if (bit_cnt == CNT_W'(BIN_W - 1)) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)
        bit_cnt <= '0;
      else if (state_q == CONVERT)
        bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start)
      shreg <= {{BCD_W{1'b0}}, bin};
    else if (state_q == CONVERT)
      shreg <= dabble_step(shreg);
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == LATCH);
  assign bcd  = shreg[BIN_W +: BCD_W];

endmodule

// File: rtl/hud_display.sv
// Game HUD: enemy count hex digit, decimal score with blanking/blink,
// collision stretcher, mode LED and charge bar, all on registered outputs.
module hud_display
  import hud_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCORE_WIDTH    = 10,
  parameter int LED_COUNT      = 10,
  parameter int STRETCH_CYCLES = 25_000_000,
  parameter int BLINK_DIV      = 12_500_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SCORE_WIDTH-1:0]  score,
  input  logic [3:0]              enemy_count,
  input  logic [3:0]              charge,
  input  logic                    mode,
  input  logic [1:0]              health,
  input  logic                    collision,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [LED_COUNT-1:0]    LEDR,
  output logic                    busy
);

  localparam int SCORE_DIGITS = NUM_DIGITS - 2;
  localparam int BAR_W        = LED_COUNT - 2;
  localparam int STR_W        = $clog2(STRETCH_CYCLES + 1);
  localparam int BLK_W        = $clog2(BLINK_DIV + 1);

  logic [SCORE_WIDTH-1:0]    last_score;
  logic                      start, cvt_busy, cvt_done;
  logic [4*SCORE_DIGITS-1:0] cvt_bcd, disp_bcd, shown_bcd;
  logic [STR_W-1:0]          stretch_cnt;
  logic [BLK_W-1:0]          blink_cnt;
  logic                      blink_off;
  logic [7*NUM_DIGITS-1:0]   hex_p0, hex_p1;
  logic [LED_COUNT-1:0]      ledr_p0, ledr_p1;
  logic                      lead;
  logic [3:0]                digit;
  logic [6:0]                seg;

  function automatic logic [BAR_W-1:0] thermo_bar(input logic [3:0] c);
    logic [BAR_W-1:0] b;
    for (int i = 0; i < BAR_W; i++)
      b[i] = (int'(c) > i);
    return b;
  endfunction

  assign start = !reset && !cvt_busy && (score != last_score);
  assign busy  = cvt_busy | start;

  bin2bcd_seq #(
    .BIN_W      (SCORE_WIDTH),
    .BCD_DIGITS (SCORE_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (score),
    .busy  (cvt_busy),
    .done  (cvt_done),
    .bcd   (cvt_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_score  <= '0;
      disp_bcd    <= '0;
      stretch_cnt <= '0;
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
    end else begin
      if (start)
        last_score <= score;
      if (cvt_done)
        disp_bcd <= cvt_bcd;
      if (collision)
        stretch_cnt <= STR_W'(STRETCH_CYCLES);
      else if (stretch_cnt != '0)
        stretch_cnt <= stretch_cnt - STR_W'(1);
      if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  // Stage p0: bypass the latch cycle so the new score reaches hex_p1 with it.
  assign shown_bcd = cvt_done ? cvt_bcd : disp_bcd;

  always_comb begin
    hex_p0        = {NUM_DIGITS{SEG_BLANK}};
    lead          = 1'b1;
    digit         = '0;
    seg           = SEG_BLANK;
    hex_p0[6:0]   = hex_to_seg(enemy_count);
    for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
      digit = shown_bcd[4*i +: 4];
      if (lead && digit == 4'd0 && i != 0) begin
        seg = SEG_BLANK;
      end else begin
        seg  = hex_to_seg(digit);
        lead = 1'b0;
      end
      if (health == 2'd1 && blink_off)
        seg = SEG_BLANK;
      hex_p0[7*(i+2) +: 7] = seg;
    end
    if (health == 2'd0)
      hex_p0 = {NUM_DIGITS{SEG_DASH}};
  end

  assign ledr_p0 = {thermo_bar(charge), mode, collision | (stretch_cnt != '0)};

  // Stage p1: registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_p1        <= {NUM_DIGITS{SEG_BLANK}};
      hex_p1[6:0]   <= SEG_ZERO;
      hex_p1[20:14] <= SEG_ZERO;
      ledr_p1       <= '0;
    end else begin
      hex_p1  <= hex_p0;
      ledr_p1 <= ledr_p0;
    end
  end

  assign hex  = hex_p1;
  assign LEDR = ledr_p1;

endmodule

// File: tb/tb_hud_display.sv
// Scoreboard bench for hud_display: score displays are queued on stimulus
// and popped by a monitor whenever the score digits change.
module tb_hud_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  score;
  logic [3:0]  enemy_count;
  logic [3:0]  charge;
  logic        mode;
  logic [1:0]  health;
  logic        collision;
  logic [41:0] hex;
  logic [9:0]  ledr;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [27:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [27:0] prev_sd;

  localparam logic [6:0]  BL = 7'h7F;
  localparam logic [41:0] HEX_RST = {BL, BL, BL, 7'h40, BL, 7'h40};

  hud_display #(
    .NUM_DIGITS     (6),
    .SCORE_WIDTH    (10),
    .LED_COUNT      (10),
    .STRETCH_CYCLES (4),
    .BLINK_DIV      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .score       (score),
    .enemy_count (enemy_count),
    .charge      (charge),
    .mode        (mode),
    .health      (health),
    .collision   (collision),
    .hex         (hex),
    .LEDR        (ledr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] score_hex(input int s);
    int dg[4];
    int v, top;
    logic [27:0] r;
    v = s;
    top = 0;
    for (int i = 0; i < 4; i++) begin
      dg[i] = v % 10;
      v = v / 10;
      if (dg[i] != 0) top = i;
    end
    for (int i = 0; i < 4; i++)
      r[7*i +: 7] = (i <= top) ? seg7(dg[i]) : BL;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: busy still high after %0d cycles", name, n);
    end
  endtask

  // Monitor: every change of the score digits must match the next queued display.
  always @(negedge clk) begin
    logic [27:0] cur, e;
    cur = hex[41:14];
    if (mon_en && cur !== prev_sd) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got %h expected no change", cur);
      end else begin
        e = exp_q.pop_front();
        check("sb_score", {36'd0, cur}, {36'd0, e});
      end
    end
    prev_sd = cur;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, falls, bad, d0bad, ntrans, gap_err, last_t;
    bit prior, s_prev;
    logic [11:0] act;
    int vals[5] = '{40, 0, 9, 100, 512};
    logic [3:0] ev[3] = '{4'hA, 4'hF, 4'h3};

    reset = 1'b1; score = '0; enemy_count = '0; charge = '0;
    mode = 1'b0; health = 2'd3; collision = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_hex", {22'd0, hex}, {22'd0, HEX_RST});
    check("rst_ledr", {54'd0, ledr}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // Max score: busy length and full digit layout
    tick();
    score = 10'd1023;
    exp_q.push_back(score_hex(1023));
    n = 0;
    do begin
      @(negedge clk);
      if (busy) n++;
    end while (busy && n < 60);
    check("busy_len", n, 12);
    check("hex_1023", {22'd0, hex}, {22'd0, seg7(1), seg7(0), seg7(2), seg7(3), BL, seg7(0)});

    // Score change mid-conversion restarts without loss
    tick();
    score = 10'd5;
    exp_q.push_back(score_hex(5));
    exp_q.push_back(score_hex(37));
    tick(); tick(); tick();
    score = 10'd37;
    falls = 0;
    prior = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (!busy && prior) falls++;
      prior = busy;
    end
    check("busy_gaps", {63'd0, (falls >= 1 && falls <= 2)}, 64'd1);
    tick();
    check("sb_drain_restart", exp_q.size(), 0);

    // Leading-zero blanking patterns
    foreach (vals[i]) begin
      tick();
      score = 10'(vals[i]);
      exp_q.push_back(score_hex(vals[i]));
      wait_idle("wait_conv");
    end
    tick();
    check("sb_drain_lz", exp_q.size(), 0);

    // Enemy digit is one cycle behind its input
    foreach (ev[i]) begin
      tick();
      enemy_count = ev[i];
      @(negedge clk);
      check("enemy_lat", {57'd0, hex[6:0]}, {57'd0, seg7((i == 0) ? 0 : int'(ev[i-1]))});
      @(negedge clk);
      check("enemy_hex", {57'd0, hex[6:0]}, {57'd0, seg7(int'(ev[i]))});
    end
    check("digit1_blank", {57'd0, hex[13:7]}, {57'd0, BL});

    // Mode latency and charge bar
    tick();
    charge = 4'd3; mode = 1'b1;
    @(negedge clk);
    check("mode_lat", {63'd0, ledr[1]}, 64'd0);
    @(negedge clk);
    check("bar_3", {55'd0, ledr[9:1]}, {55'd0, 8'b00000111, 1'b1});
    tick(); charge = 4'd15;
    @(negedge clk); @(negedge clk);
    check("bar_15", {56'd0, ledr[9:2]}, {56'd0, 8'hFF});
    tick(); charge = 4'd8;
    @(negedge clk); @(negedge clk);
    check("bar_8", {56'd0, ledr[9:2]}, {56'd0, 8'hFF});
    tick(); charge = 4'd0;
    @(negedge clk); @(negedge clk);
    check("bar_0", {56'd0, ledr[9:2]}, 64'd0);

    // Collision stretcher: single pulse, then retriggered pulse
    for (int k = 0; k < 12; k++) begin
      tick();
      collision = (k == 0);
      @(negedge clk);
      act[k] = ledr[0];
    end
    check("coll_single", {52'd0, act}, {52'd0, 12'b0000_0011_1110});
    for (int k = 0; k < 12; k++) begin
      tick();
      collision = (k == 0 || k == 3);
      @(negedge clk);
      act[k] = ledr[0];
    end
    check("coll_retrig", {52'd0, act}, {52'd0, 12'b0001_1111_1110});
    collision = 1'b0;

    // Low-health blink on score digits only
    mon_en = 1'b0;
    tick();
    health = 2'd1;
    tick(); tick();
    bad = 0; d0bad = 0; ntrans = 0; gap_err = 0; last_t = -1; s_prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bit s;
      @(negedge clk);
      s = (hex[41:14] === score_hex(512));
      if (!s && hex[41:14] !== {4{BL}}) bad++;
      if (hex[6:0] !== seg7(3)) d0bad++;
      if (k > 0 && s != s_prev) begin
        if (last_t >= 0 && (k - last_t) != 8) gap_err++;
        last_t = k;
        ntrans++;
      end
      s_prev = s;
    end
    check("blink_pattern", bad, 0);
    check("blink_digit0", d0bad, 0);
    check("blink_period", gap_err, 0);
    check("blink_toggles", {63'd0, ntrans >= 3}, 64'd1);

    // Zero health: all dashes, conversion keeps running underneath
    tick();
    health = 2'd0;
    @(negedge clk); @(negedge clk);
    check("dash_all", {22'd0, hex}, {22'd0, {6{7'b0111111}}});
    tick();
    score = 10'd77;
    wait_idle("wait_dash_conv");
    check("dash_hold", {22'd0, hex}, {22'd0, {6{7'b0111111}}});
    tick();
    health = 2'd3;
    @(negedge clk); @(negedge clk);
    check("bg_conv", {36'd0, hex[41:14]}, {36'd0, score_hex(77)});

    // Reset in the middle of a conversion
    tick();
    enemy_count = 4'd0;
    score = 10'd700;
    repeat (4) tick();
    reset = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("midrst_hex", {22'd0, hex}, {22'd0, HEX_RST});
    check("midrst_ledr", {54'd0, ledr}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    tick();
    reset = 1'b0;
    n = 0;
    @(negedge clk);
    while (hex[41:14] !== score_hex(700) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_latency", n, 12);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
